// File: rtl/rf_writeback_arb.sv
// rtl/rf_writeback_arb.sv - merges ALU and buffered load results onto the single RF write port
// ALU results always win; load results bypass when the FIFO is empty, else queue in order.
module rf_writeback_arb #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_alu_valid,
  input  logic [ADDR_W-1:0]             i_alu_waddr,
  input  logic [DATA_W-1:0]             i_alu_wdata,
  input  logic                          i_mem_valid,
  output logic                          o_mem_ready,
  input  logic [ADDR_W-1:0]             i_mem_waddr,
  input  logic [DATA_W-1:0]             i_mem_wdata,
  output logic                          o_wena,
  output logic [ADDR_W-1:0]             o_waddr,
  output logic [DATA_W-1:0]             o_wdata,
  output logic [2**ADDR_W-1:0]          o_pending,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_waw_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_wena;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_waw_err;

  logic                w_empty;
  logic                w_mem_ready;
  logic                w_accept;
  logic                w_pop;
  logic                w_bypass;
  logic                w_push;
  logic [2**ADDR_W-1:0] w_pending;

  assign w_empty     = (r_count == '0);
  assign w_mem_ready = i_rst_n && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_accept    = i_mem_valid && w_mem_ready;
  assign w_pop       = !i_alu_valid && !w_empty;
  assign w_bypass    = !i_alu_valid && w_empty && w_accept;
  assign w_push      = w_accept && !w_bypass;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count)
        w_pending[r_fifo_addr[i]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= i_mem_waddr;
      r_fifo_data[r_wr_ptr] <= i_mem_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wena    <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_waw_err <= 1'b0;
    end else begin
      r_wena <= 1'b0;
      if (i_alu_valid) begin
        r_wena  <= 1'b1;
        r_waddr <= i_alu_waddr;
        r_wdata <= i_alu_wdata;
      end else if (!w_empty) begin
        r_wena  <= 1'b1;
        r_waddr <= r_fifo_addr[r_rd_ptr];
        r_wdata <= r_fifo_data[r_rd_ptr];
      end else if (w_accept) begin
        r_wena  <= 1'b1;
        r_waddr <= i_mem_waddr;
        r_wdata <= i_mem_wdata;
      end
      if (i_alu_valid && w_pending[i_alu_waddr]) r_waw_err <= 1'b1;
    end
  end

  assign o_mem_ready  = w_mem_ready;
  assign o_wena       = r_wena;
  assign o_waddr      = r_waddr;
  assign o_wdata      = r_wdata;
  assign o_pending    = w_pending;
  assign o_fifo_count = r_count;
  assign o_waw_err    = r_waw_err;

endmodule

// File: tb/tb_rf_writeback_arb.sv
// tb/tb_rf_writeback_arb.sv - randomized and directed checks of rf_writeback_arb
// Reference model keeps the load FIFO as a queue of (addr, data) entries.
module tb_rf_writeback_arb;

  typedef struct {
    logic [2:0]  a;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [2:0]  alu_waddr = '0;
  logic [63:0] alu_wdata = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_waddr = '0;
  logic [63:0] mem_wdata = '0;
  logic        wena;
  logic [2:0]  waddr;
  logic [63:0] wdata;
  logic [7:0]  pending;
  logic [2:0]  fifo_count;
  logic        waw_err;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        q[$];
  logic        m_wena = 1'b0;
  logic [2:0]  m_waddr = '0;
  logic [63:0] m_wdata = '0;
  logic        m_waw = 1'b0;

  always #5 clk = ~clk;

  rf_writeback_arb dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_alu_valid  (alu_valid),
    .i_alu_waddr  (alu_waddr),
    .i_alu_wdata  (alu_wdata),
    .i_mem_valid  (mem_valid),
    .o_mem_ready  (mem_ready),
    .i_mem_waddr  (mem_waddr),
    .i_mem_wdata  (mem_wdata),
    .o_wena       (wena),
    .o_waddr      (waddr),
    .o_wdata      (wdata),
    .o_pending    (pending),
    .o_fifo_count (fifo_count),
    .o_waw_err    (waw_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] r = '0;
    foreach (q[i]) r[q[i].a] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic av, input logic [2:0] aa, input logic [63:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [63:0] md);
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    mem_valid = mv; mem_waddr = ma; mem_wdata = md;
  endtask

  // One clock: predict from current inputs, advance, compare every output.
  task automatic step(output bit accepted);
    logic [7:0] pend;
    bit         rdy;
    ent_t       e;
    pend = model_pending();
    rdy  = (q.size() < 4);
    check_eq("mem_ready", mem_ready, rdy);
    accepted = mem_valid && rdy;
    e.a = mem_waddr;
    e.d = mem_wdata;
    m_wena = 1'b0;
    if (alu_valid) begin
      m_wena = 1'b1; m_waddr = alu_waddr; m_wdata = alu_wdata;
      if (pend[alu_waddr]) m_waw = 1'b1;
      if (accepted) q.push_back(e);
    end else if (q.size() > 0) begin
      ent_t h;
      h = q.pop_front();
      m_wena = 1'b1; m_waddr = h.a; m_wdata = h.d;
      if (accepted) q.push_back(e);
    end else if (accepted) begin
      m_wena = 1'b1; m_waddr = mem_waddr; m_wdata = mem_wdata;
    end
    @(posedge clk); #1;
    check_eq("wena", wena, m_wena);
    check_eq("waddr", waddr, m_waddr);
    check_eq("wdata", wdata, m_wdata);
    check_eq("fifo_count", fifo_count, q.size());
    check_eq("pending", pending, model_pending());
    check_eq("waw_err", waw_err, m_waw);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_wena", wena, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_mem_ready", mem_ready, 0);
    check_eq("rst_waw_err", waw_err, 0);
    check_eq("rst_waddr", waddr, 0);
    check_eq("rst_wdata", wdata, 0);
    q.delete();
    m_wena = 1'b0; m_waddr = '0; m_wdata = '0; m_waw = 1'b0;
    repeat (2) @(posedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_wena", wena, 0);
  endtask

  task automatic random_traffic(input int cycles);
    bit acc;
    for (int c = 0; c < cycles; c++) begin
      alu_valid = ($urandom_range(0, 99) < 45);
      alu_waddr = 3'($urandom);
      alu_wdata = {$urandom, $urandom};
      if (!mem_valid && ($urandom_range(0, 1) == 1)) begin
        mem_valid = 1'b1;
        mem_waddr = 3'($urandom);
        mem_wdata = {$urandom, $urandom};
      end
      step(acc);
      if (acc) mem_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   accepted_n;
    logic [2:0] seen[$];

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // ALU write then idle
    drive(1, 3, 64'hDEAD_BEEF, 0, 0, 0);
    step(acc);
    check_eq("t2_waddr", waddr, 3);
    check_eq("t2_wdata", wdata, 64'hDEAD_BEEF);
    drive(0, 0, 0, 0, 0, 0);
    step(acc);
    check_eq("t2_idle_wena", wena, 0);

    // Bypass with empty FIFO
    drive(0, 0, 0, 1, 5, 64'h55);
    step(acc);
    check_eq("t3_wena", wena, 1);
    check_eq("t3_waddr", waddr, 5);
    check_eq("t3_count", fifo_count, 0);

    // Collision: ALU wins, load buffered
    drive(1, 1, 64'h11, 1, 2, 64'h22);
    step(acc);
    check_eq("t4_waddr1", waddr, 1);
    check_eq("t4_count", fifo_count, 1);
    check_eq("t4_pending", pending, 8'h04);
    drive(0, 0, 0, 0, 0, 0);
    step(acc);
    check_eq("t4_waddr2", waddr, 2);
    check_eq("t4_wdata2", wdata, 64'h22);
    check_eq("t4_pending0", pending, 0);

    // Fill under continuous ALU traffic, then drain
    accepted_n = 0;
    for (int k = 0; k < 6 && accepted_n < 5; k++) begin
      drive(1, 7, 64'(k), 1, 3'(accepted_n), 64'h100 + 64'(accepted_n));
      step(acc);
      if (acc) accepted_n++;
    end
    check_eq("t5_accepted", accepted_n, 4);
    check_eq("t5_count_full", fifo_count, 4);
    check_eq("t5_ready_full", mem_ready, 0);
    alu_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(acc);
      if (acc) mem_valid = 1'b0;
      if (wena) seen.push_back(waddr);
    end
    check_eq("t5_nwrites", seen.size(), 5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      check_eq($sformatf("t5_order%0d", k), seen[k], k);

    // WAW: sticky until reset
    do_reset();
    drive(1, 0, 64'h1, 1, 6, 64'h66);
    step(acc);
    check_eq("t6_pending6", pending, 8'h40);
    drive(1, 6, 64'h77, 0, 0, 0);
    step(acc);
    check_eq("t6_waw", waw_err, 1);
    random_traffic(20);
    check_eq("t6_waw_hold", waw_err, 1);
    do_reset();

    // Randomized traffic with a reset in the middle
    random_traffic(300);
    do_reset();
    random_traffic(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
